rocc_dispatch_queue: RTL and testbench
======================================

// Module: rocc_dispatch_queue
// PURPOSE
//   Parametrised RoCC command queue/dispatcher between the core WB stage and NUM_ACC accelerators.
//   Buffers up to DEPTH custom instructions with operands; the core stalls only when the queue is full or a fence waits.
//   Routes each command in order to its target accelerator with a valid/ready handshake.
//   Tracks per-channel busy state until done; adds a drain/fence mode.
// PARAMETERS
//   DEPTH    4   queue entries, power of two, >=2
//   NUM_ACC  2   accelerator channels, 1..8
//   XLEN     32  operand width
//   CH_W     $clog2(NUM_ACC) (min 1), derived; channel-field width
// PORTS
//   clk        in   1            clock, rising edge
//   rst        in   1            asynchronous, active-low reset
//   cmd_valid  in   1            WB stage presents a custom (GEMM-class) instruction
//   cmd_fence  in   1            with cmd_valid: fence; wait until everything is drained, not enqueued
//   cmd_instr  in   32           instruction word; channel = cmd_instr[12 +: CH_W]
//   cmd_rs1    in   XLEN         forwarded rs1 value
//   cmd_rs2    in   XLEN         forwarded rs2 value
//   stall      out  1            hold the pipeline; command not accepted this cycle
//   acc_valid  out  NUM_ACC      one-hot; head command offered to channel
//   acc_ready  in   NUM_ACC      channel accepts
//   acc_instr  out  32           shared command bus, instruction
//   acc_rs1    out  XLEN         shared command bus, operand 1
//   acc_rs2    out  XLEN         shared command bus, operand 2
//   acc_done   in   NUM_ACC      1-cycle pulse per channel; command finished
//   busy       out  1            queue non-empty OR any channel busy
//   err        out  1            1-cycle pulse: bad channel dropped or spurious done
// BEHAVIOUR
//   Reset (rst=0, async): queue empty, ptrs=0, ch_busy=0. stall, acc_valid, err = 0. acc_* bus = 0.
//   Enqueue: cmd_valid & !cmd_fence & !full & chan<NUM_ACC -> write entry at wr_ptr, count+1, stall=0.
//     cmd_valid & !cmd_fence & full -> stall=1 (combinational), nothing written.
//     chan>=NUM_ACC -> not enqueued, stall=0, err=1 for one cycle.
//   Fence: cmd_valid & cmd_fence -> stall=1 while (count!=0 | ch_busy!=0).
//     First cycle both are clear -> stall=0, fence consumed; no other side effect.
//   Dispatch: strict in-order; head only; no bypass.
//     Command written at cycle N is offered no earlier than cycle N+1.
//     acc_valid[head.ch]=1 when count!=0 & !ch_busy[head.ch]; acc_* bus = head entry.
//     Handshake acc_valid[c]&acc_ready[c] -> pop head, set ch_busy[c] next cycle.
//     Once raised, valid and bus stay stable until ready.
//   Head-of-line: if head channel is busy, later commands to idle channels wait.
//   Completion: acc_done[c] & ch_busy[c] -> clear ch_busy[c].
//     acc_done[c] & !ch_busy[c] -> ignored, err=1.
//     Same-cycle done[c] and handshake on c -> ch_busy[c] stays 1 (new command owns it).
//   Simultaneous push+pop: allowed when !full; count unchanged; full blocks push even if a pop occurs.
//   Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, 0..DEPTH.
//   err is registered; several causes in one cycle still give a single pulse.
//   Reset mid-operation: queue and busy flags cleared immediately; in-flight commands are abandoned.
// TESTING
//   1 Reset: rst=0 during traffic -> acc_valid=0, stall=0, busy=0 next edge and while held.
//   2 Single cmd ch0 (instr[12]=0, rs1=0x10, rs2=0x20), acc_ready=1
//       -> acc_valid=2'b01 cycle N+1 with rs1=0x10, rs2=0x20; busy until acc_done[0]; then busy=0.
//   3 Fill: DEPTH=4, acc_ready=0, push 5 cmds back-to-back
//       -> 4 accepted, 5th sees stall=1 until first pop; order preserved (check instr words).
//   4 HOL: ch0 busy, queue {ch0, ch1}
//       -> acc_valid stays 0 for ch1 until acc_done[0]; then ch0 cmd dispatched, then ch1.
//   5 Fence with 2 outstanding -> stall=1 until the last acc_done; stall falls in the cycle after busy clears.
//       Queue unchanged by the fence.
//   6 Errors: cmd to channel 3 with NUM_ACC=2 -> err pulse, count unchanged.
//       acc_done[1] while idle -> err pulse.
//       Same-cycle done+handshake on ch0 -> ch_busy[0]=1.

Source files
------------

// File: rtl/rocc_dispatch_queue.sv
// RoCC command queue: buffers DEPTH custom instructions and dispatches them in order to NUM_ACC channels.
// Latency: a command written at cycle N is offered at N+1 at the earliest; stall and acc_valid are combinational.
// Backpressure: stall when the queue is full or a fence waits; the head holds acc_valid and the bus until acc_ready.
module rocc_dispatch_queue #(
  parameter int DEPTH   = 4,
  parameter int NUM_ACC = 2,
  parameter int XLEN    = 32,
  parameter int CH_W    = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic               cmd_fence,
  input  logic [31:0]        cmd_instr,
  input  logic [XLEN-1:0]    cmd_rs1,
  input  logic [XLEN-1:0]    cmd_rs2,
  output logic               stall,
  output logic [NUM_ACC-1:0] acc_valid,
  input  logic [NUM_ACC-1:0] acc_ready,
  output logic [31:0]        acc_instr,
  output logic [XLEN-1:0]    acc_rs1,
  output logic [XLEN-1:0]    acc_rs2,
  input  logic [NUM_ACC-1:0] acc_done,
  output logic               busy,
  output logic               err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Queue storage; not reset because every read is gated by count.
  logic [31:0]     q_instr [DEPTH];
  logic [XLEN-1:0] q_rs1   [DEPTH];
  logic [XLEN-1:0] q_rs2   [DEPTH];

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic [NUM_ACC-1:0] ch_busy;

  logic               full;
  logic               empty;
  logic [2:0]         cmd_chan_wide;
  logic               chan_bad;
  logic               push;
  logic               pop;
  logic [CH_W-1:0]    head_ch;
  logic               offer;
  logic [NUM_ACC-1:0] handshake;
  logic               spurious_done;
  logic               err_nxt;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // The channel range check looks at the full 3-bit field (up to 8 channels) so an
  // out-of-range channel is caught even when CH_W alone could not encode it.
  assign cmd_chan_wide = cmd_instr[14:12];
  assign chan_bad      = ({1'b0, cmd_chan_wide} >= 4'(NUM_ACC));

  assign push = cmd_valid & ~cmd_fence & ~chan_bad & ~full;

  assign head_ch = q_instr[rd_ptr][12 +: CH_W];
  assign offer   = ~empty & ~ch_busy[head_ch];

  // Offer the head command to its channel; bus is zero while the queue is empty.
  always_comb begin
    acc_valid = '0;
    acc_instr = '0;
    acc_rs1   = '0;
    acc_rs2   = '0;
    if (!empty) begin
      acc_instr = q_instr[rd_ptr];
      acc_rs1   = q_rs1[rd_ptr];
      acc_rs2   = q_rs2[rd_ptr];
    end
    if (offer) begin
      acc_valid[head_ch] = 1'b1;
    end
  end

  assign handshake = acc_valid & acc_ready;
  assign pop       = |handshake;

  // Pipeline hold: full queue for a normal command, or a fence with work still outstanding.
  // A bad-channel command is never stalled: it is dropped with an error instead.
  always_comb begin
    stall = 1'b0;
    if (cmd_valid) begin
      if (cmd_fence) begin
        stall = ~empty | (|ch_busy);
      end else if (!chan_bad) begin
        stall = full;
      end
    end
  end

  assign busy = ~empty | (|ch_busy);

  assign spurious_done = |(acc_done & ~ch_busy);
  assign err_nxt       = (cmd_valid & ~cmd_fence & chan_bad) | spurious_done;

  // Write the incoming command into the slot at wr_ptr.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= cmd_instr;
      q_rs1[wr_ptr]   <= cmd_rs1;
      q_rs2[wr_ptr]   <= cmd_rs2;
    end
  end

  // Pointers, occupancy, per-channel busy flags and the error pulse.
  // A dispatch in the same cycle as a done on that channel leaves it busy for the new command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ch_busy <= '0;
      err     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      ch_busy <= (ch_busy & ~acc_done) | handshake;
      err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_rocc_dispatch_queue.sv
// Directed bench for rocc_dispatch_queue (DEPTH=4, NUM_ACC=2, XLEN=32).
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after the edge.
// Expected values are hand-derived constants per step.
module tb_rocc_dispatch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_fence;
  logic [31:0] cmd_instr;
  logic [31:0] cmd_rs1;
  logic [31:0] cmd_rs2;
  logic        stall;
  logic [1:0]  acc_valid;
  logic [1:0]  acc_ready;
  logic [31:0] acc_instr;
  logic [31:0] acc_rs1;
  logic [31:0] acc_rs2;
  logic [1:0]  acc_done;
  logic        busy;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  rocc_dispatch_queue #(.DEPTH(4), .NUM_ACC(2), .XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_fence (cmd_fence),
    .cmd_instr (cmd_instr),
    .cmd_rs1   (cmd_rs1),
    .cmd_rs2   (cmd_rs2),
    .stall     (stall),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc_instr (acc_instr),
    .acc_rs1   (acc_rs1),
    .acc_rs2   (acc_rs2),
    .acc_done  (acc_done),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int ch, input int id);
    return 32'h0000_000B | (32'(ch) << 12) | (32'(id) << 20);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_fence = 1'b0;
    cmd_instr = '0;
    cmd_rs1   = '0;
    cmd_rs2   = '0;
    acc_ready = '0;
    acc_done  = '0;

    // Reset state
    tick(); tick();
    #1;
    chk("rst_acc_valid", 32'(acc_valid), 32'h0);
    chk("rst_stall",     32'(stall),     32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_err",       32'(err),       32'h0);
    chk("rst_bus",       acc_instr,      32'h0);
    tick();
    rst = 1'b1;

    // Single command on channel 0
    tick();
    cmd_valid = 1'b1; cmd_instr = mk(0, 1); cmd_rs1 = 32'h10; cmd_rs2 = 32'h20;
    #1;
    chk("single_stall",    32'(stall),     32'h0);
    chk("single_nobypass", 32'(acc_valid), 32'h0);
    tick();
    cmd_valid = 1'b0; acc_ready = 2'b01;
    #1;
    chk("single_valid", 32'(acc_valid), 32'h1);
    chk("single_instr", acc_instr,      mk(0, 1));
    chk("single_rs1",   acc_rs1,        32'h10);
    chk("single_rs2",   acc_rs2,        32'h20);
    tick();
    acc_ready = 2'b00;
    #1;
    chk("single_popped",  32'(acc_valid), 32'h0);
    chk("single_chbusy",  32'(busy),      32'h1);
    tick();
    acc_done = 2'b01;
    #1;
    chk("single_busy_pre_done", 32'(busy), 32'h1);
    tick();
    acc_done = 2'b00;
    #1;
    chk("single_idle",  32'(busy), 32'h0);
    chk("single_noerr", 32'(err),  32'h0);

    // Fill: four accepted, fifth stalls until a pop frees a slot
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_instr = mk(0, i + 2); cmd_rs1 = 32'(i); cmd_rs2 = 32'(i);
      #1;
      chk("fill_accept_stall", 32'(stall), 32'h0);
      tick();
    end
    cmd_instr = mk(0, 6);
    #1;
    chk("fill_full_stall", 32'(stall),     32'h1);
    chk("fill_head_valid", 32'(acc_valid), 32'h1);
    chk("fill_head_instr", acc_instr,      mk(0, 2));
    tick();
    #1;
    chk("fill_still_stall", 32'(stall), 32'h1);
    acc_ready = 2'b01;
    #1;
    chk("fill_stall_during_pop", 32'(stall), 32'h1);
    tick();
    acc_ready = 2'b00;
    #1;
    chk("fill_stall_released", 32'(stall), 32'h0);
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      acc_done = 2'b01;
      tick();
      acc_done = 2'b00;
      #1;
      chk("fill_order_valid", 32'(acc_valid), 32'h1);
      chk("fill_order_instr", acc_instr,      mk(0, k + 3));
      acc_ready = 2'b01;
      tick();
      acc_ready = 2'b00;
    end
    acc_done = 2'b01;
    tick();
    acc_done = 2'b00;
    #1;
    chk("fill_drained", 32'(busy), 32'h0);

    // Head-of-line blocking
    cmd_valid = 1'b1; cmd_instr = mk(0, 7); tick();
    cmd_instr = mk(0, 8); tick();
    cmd_instr = mk(1, 9); tick();
    cmd_valid = 1'b0;
    #1;
    chk("hol_a_valid", 32'(acc_valid), 32'h1);
    chk("hol_a_instr", acc_instr,      mk(0, 7));
    acc_ready = 2'b11;
    tick();
    #1;
    chk("hol_blocked", 32'(acc_valid), 32'h0);
    tick();
    #1;
    chk("hol_still_blocked", 32'(acc_valid), 32'h0);
    acc_done = 2'b01;
    tick();
    acc_done = 2'b00;
    #1;
    chk("hol_b_valid", 32'(acc_valid), 32'h1);
    chk("hol_b_instr", acc_instr,      mk(0, 8));
    tick();
    #1;
    chk("hol_c_valid", 32'(acc_valid), 32'h2);
    chk("hol_c_instr", acc_instr,      mk(1, 9));
    tick();
    acc_ready = 2'b00;
    #1;
    chk("hol_all_sent", 32'(acc_valid), 32'h0);
    chk("hol_busy",     32'(busy),      32'h1);

    // Fence with two channels outstanding
    cmd_valid = 1'b1; cmd_fence = 1'b1; cmd_instr = mk(0, 10);
    #1;
    chk("fence_stall_2", 32'(stall), 32'h1);
    acc_done = 2'b01;
    tick();
    acc_done = 2'b00;
    #1;
    chk("fence_stall_1", 32'(stall), 32'h1);
    acc_done = 2'b10;
    tick();
    acc_done = 2'b00;
    #1;
    chk("fence_release", 32'(stall), 32'h0);
    chk("fence_idle",    32'(busy),  32'h0);
    tick();
    cmd_valid = 1'b0; cmd_fence = 1'b0;
    #1;
    chk("fence_not_queued", 32'(busy),      32'h0);
    chk("fence_no_offer",   32'(acc_valid), 32'h0);

    // Errors: bad channel, spurious done
    cmd_valid = 1'b1; cmd_instr = mk(3, 11);
    #1;
    chk("badch_stall", 32'(stall), 32'h0);
    tick();
    cmd_valid = 1'b0;
    #1;
    chk("badch_err",     32'(err),  32'h1);
    chk("badch_dropped", 32'(busy), 32'h0);
    tick();
    #1;
    chk("badch_err_pulse", 32'(err), 32'h0);
    acc_done = 2'b10;
    tick();
    acc_done = 2'b00;
    #1;
    chk("spurious_err", 32'(err), 32'h1);
    tick();
    #1;
    chk("spurious_err_pulse", 32'(err), 32'h0);

    // Same-cycle done and handshake on channel 0 keeps it busy
    cmd_valid = 1'b1; cmd_instr = mk(0, 12);
    tick();
    cmd_valid = 1'b0; acc_ready = 2'b01; acc_done = 2'b01;
    #1;
    chk("samecyc_valid", 32'(acc_valid), 32'h1);
    tick();
    acc_ready = 2'b00; acc_done = 2'b00;
    #1;
    chk("samecyc_chbusy", 32'(busy), 32'h1);
    acc_done = 2'b01;
    tick();
    acc_done = 2'b00;
    #1;
    chk("samecyc_done", 32'(busy), 32'h0);

    // Reset in the middle of traffic
    cmd_valid = 1'b1; cmd_instr = mk(0, 13); tick();
    cmd_instr = mk(1, 14); tick();
    #1;
    chk("midrst_pre_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(acc_valid), 32'h0);
    chk("midrst_busy",  32'(busy),      32'h0);
    chk("midrst_stall", 32'(stall),     32'h0);
    tick(); tick();
    #1;
    chk("midrst_held_valid", 32'(acc_valid), 32'h0);
    chk("midrst_held_busy",  32'(busy),      32'h0);
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
